// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR phase-interpolator code generator.
// Combinational helpers only; no state lives here.
// No backpressure: all consumers take one value per clock.
package cdr_pkg;

    // Default PI code geometry: 3-bit octant sector + 8-bit blend weight.
    localparam int CODE_W_DEF  = 11;
    // Fractional phase bits kept below the code LSB.
    localparam int PH_FRAC_DEF = 8;

    // Signed decision / vote: -1 retard, 0 hold, +1 advance.
    typedef enum logic signed [1:0] {
        VOTE_DN   = 2'sb11,
        VOTE_NONE = 2'sb00,
        VOTE_UP   = 2'sb01
    } vote_e;

    // Symmetric saturating add used by the frequency integrator.
    // The result is clamped to [-lim, +lim]; operands are small enough
    // that the 32-bit intermediate sum cannot overflow.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] lim
    );
        logic signed [31:0] s;
        s = a + b;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/cdr_vote_window.sv
// Decimating bang-bang voter: sums Up/Dn votes over DECIM enabled cycles.
// Latency: dec_valid is combinational on the window's final enabled cycle.
// No backpressure: EN low freezes the window; Load clears it.
module cdr_vote_window
    import cdr_pkg::*;
#(
    parameter int DECIM = 8
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  EN,
    input  logic  Up,
    input  logic  Dn,
    input  logic  Load,
    output logic  dec_valid,
    output vote_e dec
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    // Sum spans -DECIM..+DECIM, so one sign bit on top of the magnitude.
    localparam int SUM_W = $clog2(DECIM + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0]        count;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [1:0]       vote_v;
    vote_e                   vote;
    logic                    last;

    // Per-cycle vote: conflicting or absent votes count as zero.
    always_comb begin
        vote = VOTE_NONE;
        if (Up && !Dn) begin
            vote = VOTE_UP;
        end else if (Dn && !Up) begin
            vote = VOTE_DN;
        end
    end

    assign vote_v  = vote;
    assign sum_nxt = sum + SUM_W'(vote_v);
    assign last    = (count == CNT_LAST);

    // Window end fires only when enabled and not overridden by a preset.
    assign dec_valid = EN && last && !Load;

    // Decision is the sign of the sum including this cycle's vote.
    always_comb begin
        dec = VOTE_NONE;
        if (sum_nxt > 0) begin
            dec = VOTE_UP;
        end else if (sum_nxt < 0) begin
            dec = VOTE_DN;
        end
    end

    // Window position and running sum; held while EN is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
            sum   <= '0;
        end else if (Load) begin
            count <= '0;
            sum   <= '0;
        end else if (EN) begin
            if (last) begin
                count <= '0;
                sum   <= '0;
            end else begin
                count <= count + 1'b1;
                sum   <= sum_nxt;
            end
        end
    end

endmodule

// File: rtl/cdr_pi_code_gen.sv
// CDR loop filter producing the phase-interpolator code; optional integral path under CDR_FREQ_PATH_EN.
// Latency: Code/Code_Valid update on the DECIM-th enabled cycle of a window, or on the Load edge.
// No backpressure: the PI consumes every code; EN low stalls the loop, Load presets it.
module cdr_pi_code_gen
    import cdr_pkg::*;
#(
    parameter int CODE_W    = CODE_W_DEF,
    parameter int PH_FRAC   = PH_FRAC_DEF,
    parameter int DECIM     = 8,
    parameter int KP        = 256,
    parameter int KI        = 1,
    parameter int INT_W     = 16,
    parameter int INT_SHIFT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    Up,
    input  logic                    Dn,
    input  logic                    Load,
    input  logic [CODE_W-1:0]       Code_Init,
    output logic [CODE_W-1:0]       Code,
    output logic                    Code_Valid,
    output logic signed [INT_W-1:0] Freq_Word
);

    localparam int ACC_W = CODE_W + PH_FRAC;
    localparam logic [ACC_W-1:0] KP_STEP = ACC_W'(KP);

    logic [ACC_W-1:0] phase_acc;
    logic [ACC_W-1:0] prop_step;
    logic [ACC_W-1:0] phase_step;
    logic             dec_valid;
    vote_e            dec;

    cdr_vote_window #(
        .DECIM (DECIM)
    ) u_vote (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .Up        (Up),
        .Dn        (Dn),
        .Load      (Load),
        .dec_valid (dec_valid),
        .dec       (dec)
    );

    // Proportional phase kick; negative steps rely on modulo wrap of the accumulator.
    always_comb begin
        prop_step = '0;
        case (dec)
            VOTE_UP: prop_step = KP_STEP;
            VOTE_DN: prop_step = '0 - KP_STEP;
            default: prop_step = '0;
        endcase
    end

`ifdef CDR_FREQ_PATH_EN
    localparam logic signed [31:0] SAT_LIM = (32'sd1 <<< (INT_W - 1)) - 32'sd1;

    logic signed [INT_W-1:0] freq;
    logic signed [INT_W-1:0] freq_shr;
    logic signed [INT_W-1:0] freq_nxt;
    logic signed [31:0]      int_inc;
    logic [ACC_W-1:0]        int_step;

    // Integrator increment for this decision.
    always_comb begin
        int_inc = 32'sd0;
        case (dec)
            VOTE_UP: int_inc = 32'(KI);
            VOTE_DN: int_inc = -32'(KI);
            default: int_inc = 32'sd0;
        endcase
    end

    // Frequency contribution uses the pre-update integrator, sign-extended into the accumulator.
    assign freq_shr   = freq >>> INT_SHIFT;
    assign int_step   = ACC_W'(freq_shr);
    assign freq_nxt   = INT_W'(sat_add(32'(freq), int_inc, SAT_LIM));
    assign phase_step = prop_step + int_step;
    assign Freq_Word  = freq;

    // Integrator register: cleared by preset, saturating otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            freq <= '0;
        end else if (Load) begin
            freq <= '0;
        end else if (dec_valid) begin
            freq <= freq_nxt;
        end
    end
`else
    // First-order loop: no frequency state at all.
    assign phase_step = prop_step;
    assign Freq_Word  = '0;
`endif

    // Phase accumulator and update strobe; preset wins over a coincident window end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_acc  <= '0;
            Code_Valid <= 1'b0;
        end else if (Load) begin
            phase_acc  <= {Code_Init, {PH_FRAC{1'b0}}};
            Code_Valid <= 1'b1;
        end else if (dec_valid) begin
            phase_acc  <= phase_acc + phase_step;
            Code_Valid <= 1'b1;
        end else begin
            Code_Valid <= 1'b0;
        end
    end

    // Code is the integer part of the registered accumulator.
    assign Code = phase_acc[ACC_W-1 -: CODE_W];

endmodule

// File: doc/cdr_pi_code_gen.md
Name: cdr_pi_code_gen

Overview:
Digital CDR loop filter that produces the 11-bit phase-interpolator Code consumed by the PMA RX phase mixer (Code[10:8] = octant sector, Code[7:0] = blend weight).
- Takes per-cycle early/late votes (Up/Dn) from the bang-bang phase detector and decimates them over a fixed window.
- Drives a second-order loop: a proportional phase step plus an integral frequency path, which tracks the PPM offset.
- Code is the top bits of a modulo phase accumulator and wraps seamlessly across 0x7FF -> 0x000.

Parameters:
- CODE_W, 11, PI code width (sector + weight)
- PH_FRAC, 8, fractional bits below the code LSB in the phase accumulator
- DECIM, 8, vote window length in cycles (>= 2)
- KP, 256, proportional step per decision, in accumulator LSBs (256 = 1 code step)
- KI, 1, integrator step per decision
- INT_W, 16, signed integrator width
- INT_SHIFT, 4, arithmetic right shift applied to the integrator before it is added to the phase

Ports:
- CLK, input, 1, loop clock (recovered/divided clock domain)
- RST, input, 1, asynchronous active-high reset
- EN, input, 1, loop enable
- Up, input, 1, phase detector "late" vote (advance phase)
- Dn, input, 1, phase detector "early" vote (retard phase)
- Load, input, 1, one-cycle request to preset the code
- Code_Init, input, CODE_W, preset value used with Load
- Code, output, CODE_W, PI control code
- Code_Valid, output, 1, one-cycle pulse when Code has been updated
- Freq_Word, output, INT_W, signed integrator value (frequency estimate)

Behaviour:
- One clock; reset is asynchronous and active-high on RST; all state is clocked on posedge CLK.
- Reset values: Code = 0, Code_Valid = 0, Freq_Word = 0, phase accumulator = 0, window count = 0, vote sum = 0.
- Per-cycle vote, counted only when EN = 1:
  - Up & !Dn -> +1
  - Dn & !Up -> -1
  - both or neither -> 0
- Window handling:
  - The count runs 0..DECIM-1. The signed vote sum accumulates and includes the vote of the final cycle.
  - On the edge where count = DECIM-1: decision d = sign(sum) (+1, -1, or 0 on a tie). The count and sum then clear.
- Update on the window-end edge, using the pre-update integrator value I:
  - phase_acc (CODE_W+PH_FRAC bits, unsigned, mod 2^(CODE_W+PH_FRAC)) <= phase_acc + d*KP + sign_extend(I >>> INT_SHIFT)
  - I <= sat(I + d*KI); saturation limits are ±(2^(INT_W-1)-1)
- Outputs:
  - Code = phase_acc[MSB -: CODE_W]. It is registered, so the new value appears on that edge.
  - Code_Valid is high for exactly that one cycle, including when d = 0.
  - Freq_Word = I.
- Update latency: DECIM cycles from the first vote of a window.
- EN = 0: votes are ignored, count and sum hold, and there are no updates. The window resumes from its held position when EN returns to 1.
- Load = 1 takes priority over EN and over a window end on the same edge. It performs:
  - phase_acc <= {Code_Init, PH_FRAC'b0}; I <= 0
  - count <= 0; sum <= 0; that cycle's vote is discarded
  - Code_Valid <= 1 for that one cycle
- Wrap-around: sector 7 advances to sector 0 modulo 2^CODE_W with no glitch or hold. Negative steps wrap 0x000 -> 0x7FF.
- Reset asserted mid-window: all state clears immediately (asynchronous). The first window after release starts at count 0.

Optional Feature:
CDR_FREQ_PATH_EN
- Defined: integral path present as described above.
- Undefined: first-order loop only. There is no integrator register, Freq_Word is tied to 0, and the phase update is phase_acc + d*KP.

Decomposition:
- Package cdr_pkg:
  - CODE_W and PH_FRAC defaults
  - vote_e enum {VOTE_DN = -1, VOTE_NONE = 0, VOTE_UP = +1} as a 2-bit signed type
  - sat_add function for the integrator
- Sub-module cdr_vote_window:
  - Holds the decimating voter (count, sum, EN hold, Load clear).
  - Outputs: dec_valid and dec (vote_e).
- The top level holds the integrator, phase accumulator and output registers.

Test Plan:
Defaults apply, with CDR_FREQ_PATH_EN defined unless noted.
1. Reset: assert RST mid-window with Up=1 -> Code = 0x000, Code_Valid = 0, Freq_Word = 0 immediately. After release, the first Code_Valid arrives exactly 8 EN cycles later.
2. Load then advance: Load with Code_Init = 0x080, then 8 cycles of Up=1 -> Code = 0x081 with a one-cycle Code_Valid on the 8th edge, Freq_Word = 1.
3. Wrap:
   - Load 0x7FF, then 8 Up cycles -> Code = 0x000.
   - Load 0x000, then 8 Dn cycles -> Code = 0x7FF.
4. Tie/none: 4 Up plus 4 Dn cycles -> Code unchanged, Code_Valid pulses, Freq_Word unchanged. With Up=Dn=1 for 8 cycles -> same result.
5. Frequency tracking from Load 0x000 with continuous Up:
   - After 16 windows -> Code = 0x010, Freq_Word = 16.
   - 17th window -> phase step is 257 LSBs, so Code = 0x011 and the fractional part = 1.
   - With CDR_FREQ_PATH_EN undefined -> Freq_Word stays 0.
6. Priority/saturation:
   - Load coincident with the window-end edge -> Code = Code_Init and that window's decision is discarded.
   - EN low for 5 cycles mid-window -> the window completes 5 cycles late.
   - Continuous Up until Freq_Word = 32767, then one Dn window -> Freq_Word = 32766.
